// File: rtl/ifetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours.
//   CPU_AW / CPU_DW : instruction address and word widths
//   F_*             : instruction field positions consumed by decode
//   CLS_*           : encodings of the 2-bit instruction class field
package ifetch_unit_pkg;
    localparam int CPU_AW = 6;
    localparam int CPU_DW = 32;

    // Instruction fields: [1:0] class, [7:2] op, [15:8] rd, [23:16] rs, [31:24] imm
    localparam int F_CLS_LSB = 0;
    localparam int F_CLS_MSB = 1;
    localparam int F_OP_LSB  = 2;
    localparam int F_OP_MSB  = 7;
    localparam int F_RD_LSB  = 8;
    localparam int F_RD_MSB  = 15;
    localparam int F_RS_LSB  = 16;
    localparam int F_RS_MSB  = 23;
    localparam int F_IMM_LSB = 24;
    localparam int F_IMM_MSB = 31;

    typedef enum logic [1:0] {
        CLS_R    = 2'b00,
        CLS_I    = 2'b01,
        CLS_LDST = 2'b10
    } instr_class_e;
endpackage

// File: rtl/ifetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid flag plus the captured instruction and its PC.
//   clk, rst       : clock, async active-high reset (clears everything)
//   load_i         : capture instr_i/pc_i and mark valid (wins over flush_i)
//   flush_i        : clear valid, keep instr/pc contents
//   instr_i, pc_i  : word and address being fetched this cycle
//   valid_o, instr_o, pc_o : registered contents
module ifetch_unit_if_id_reg #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          flush_i,
    input  logic [DW-1:0] instr_i,
    input  logic [AW-1:0] pc_i,
    output logic          valid_o,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] pc_o
);
    logic          valid_q;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and captures the combinationally returned word into the IF/ID register.
//   clk, rst                    : clock, async active-high reset
//   en                          : fetch enable (0 = drain only)
//   addr_code                   : memory address, equals the PC
//   code                        : instruction returned for addr_code
//   redirect_valid, redirect_pc : taken branch/jump from execute
//   if_valid, if_instr, if_pc   : IF/ID register contents to decode
//   id_ready                    : decode accepts the current word
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int            AW       = CPU_AW,
    parameter int            DW       = CPU_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr_code,
    input  logic [DW-1:0] code,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          id_ready
);
    logic [AW-1:0] pc_q, pc_d;
    logic          fire, accept, flush;

    // A fetch needs a free slot: either the register is empty or decode drains it now.
    assign fire   = en & ~redirect_valid & (~if_valid | id_ready);
    assign accept = if_valid & id_ready;
    // Drop the slot on a redirect, or when decode drains it and nothing refills it.
    assign flush  = redirect_valid | (accept & ~fire);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (fire)
            pc_d = pc_q + AW'(1);   // wraps modulo 2^AW
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign addr_code = pc_q;

    ifetch_unit_if_id_reg #(.AW(AW), .DW(DW)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (fire),
        .flush_i (flush),
        .instr_i (code),
        .pc_i    (pc_q),
        .valid_o (if_valid),
        .instr_o (if_instr),
        .pc_o    (if_pc)
    );
endmodule
